regfile_writer: RTL and testbench

Write-side front end for the 32 x 32-bit register file. Accepts completed results from the ALU (single-cycle) and the load unit (LSU), buffers ALU results in a small FIFO, arbitrates one write per cycle and drives the register file write port (wr_en/regW/portW). Also keeps the busy scoreboard that the decode stage uses to stall RAW hazards until a destination register has been written.

---
 rtl/rv_pkg.sv | 16 +
 rtl/wb_fifo.sv | 50 +++++
 rtl/regfile_writer.sv | 109 ++++++++++
 tb/tb_regfile_writer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V core types: architectural sizes and the writeback entry
// carried from execution units to the register file.
package rv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int RW    = $clog2(NREGS);

    typedef logic [RW-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t        rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  wb_entry_t                din_i,
    input  logic                     pop_i,
    output wb_entry_t                dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   cnt_q;
    wb_entry_t     mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
            if (push_i && !pop_i)
                cnt_q <= cnt_q + 1'b1;
            else if (pop_i && !push_i)
                cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rptr_q];
    assign count_o = cnt_q;
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/regfile_writer.sv
// Register file write-side front end: buffers ALU results, arbitrates
// against LSU loads, drives the write port and tracks pending writes.
module regfile_writer
    import rv_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [RW-1:0]    alu_rd,
    input  logic [XLEN-1:0]  alu_data,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [RW-1:0]    mem_rd,
    input  logic [XLEN-1:0]  mem_data,
    input  logic             issue_valid,
    input  logic [RW-1:0]    issue_rd,
    output logic [NREGS-1:0] busy,
    output logic             wr_en,
    output logic [RW-1:0]    regW,
    output logic [XLEN-1:0]  portW
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_cnt;
    wb_entry_t        fifo_din;
    wb_entry_t        fifo_head;

    logic             wr_en_q,  wr_en_d;
    reg_idx_t         regW_q,   regW_d;
    logic [XLEN-1:0]  portW_q,  portW_d;
    logic [NREGS-1:0] busy_q,   busy_d;

    logic             room;

    assign room      = (fifo_cnt != CW'(FIFO_DEPTH));
    assign alu_ready = !rst && room;
    assign mem_ready = !rst && room;

    // Writes to x0 complete the handshake but never enter the FIFO.
    assign fifo_push = alu_valid && alu_ready && (alu_rd != '0);
    assign fifo_din  = '{rd: alu_rd, data: alu_data};

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        fifo_pop = 1'b0;
        wr_en_d  = 1'b0;
        regW_d   = regW_q;
        portW_d  = portW_q;
        if (fifo_full || (!mem_valid && !fifo_empty)) begin
            fifo_pop = 1'b1;
            wr_en_d  = 1'b1;
            regW_d   = fifo_head.rd;
            portW_d  = fifo_head.data;
        end else if (mem_valid && mem_rd != '0) begin
            wr_en_d  = 1'b1;
            regW_d   = mem_rd;
            portW_d  = mem_data;
        end
    end

    // Clear from the committing write first so a same-cycle issue wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_q)
            busy_d[regW_q] = 1'b0;
        if (issue_valid && issue_rd != '0)
            busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q <= 1'b0;
            regW_q  <= '0;
            portW_q <= '0;
            busy_q  <= '0;
        end else begin
            wr_en_q <= wr_en_d;
            regW_q  <= regW_d;
            portW_q <= portW_d;
            busy_q  <= busy_d;
        end
    end

    assign wr_en = wr_en_q;
    assign regW  = regW_q;
    assign portW = portW_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_regfile_writer.sv
// Directed bench for regfile_writer: expected writes are queued at
// stimulus time and a negedge monitor matches them against the port.
module tb_regfile_writer;
    import rv_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             alu_valid, alu_ready;
    logic [RW-1:0]    alu_rd;
    logic [XLEN-1:0]  alu_data;
    logic             mem_valid, mem_ready;
    logic [RW-1:0]    mem_rd;
    logic [XLEN-1:0]  mem_data;
    logic             issue_valid;
    logic [RW-1:0]    issue_rd;
    logic [NREGS-1:0] busy;
    logic             wr_en;
    logic [RW-1:0]    regW;
    logic [XLEN-1:0]  portW;

    int checks = 0;
    int errors = 0;
    wb_entry_t exp_q [$];

    regfile_writer #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy        (busy),
        .wr_en       (wr_en),
        .regW        (regW),
        .portW       (portW)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [RW-1:0] rd, input logic [XLEN-1:0] d);
        exp_q.push_back('{rd: rd, data: d});
    endtask

    task automatic idle;
        alu_valid   = 1'b0;
        mem_valid   = 1'b0;
        issue_valid = 1'b0;
    endtask

    // Monitor: every write must match the head of the scoreboard queue,
    // and decode must never issue to a busy register unless it frees now.
    always @(negedge clk) begin
        wb_entry_t e;
        if (!rst) begin
            if (wr_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got x%0d=%h expected none",
                             regW, portW);
                end else begin
                    e = exp_q.pop_front();
                    if (regW !== e.rd || portW !== e.data) begin
                        errors++;
                        $display("FAIL write: got x%0d=%h expected x%0d=%h",
                                 regW, portW, e.rd, e.data);
                    end
                end
            end
            if (issue_valid && issue_rd != '0) begin
                checks++;
                if (busy[issue_rd] && !(wr_en && regW == issue_rd)) begin
                    errors++;
                    $display("FAIL issue_busy: got busy[%0d]=1 expected 0",
                             issue_rd);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle();
        alu_rd = '0; alu_data = '0;
        mem_rd = '0; mem_data = '0;
        issue_rd = '0;

        // reset state
        @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_regW", 32'(regW), 0);
        chk("rst_portW", portW, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_ready", 32'(alu_ready), 0);
        chk("rst_mem_ready", 32'(mem_ready), 0);
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("rel_alu_ready", 32'(alu_ready), 1);
        chk("rel_mem_ready", 32'(mem_ready), 1);

        // single ALU write: handshake c0, wr_en in c2 only
        tick();
        alu_valid = 1'b1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        expect_wr(5, 32'hDEADBEEF);
        @(negedge clk); chk("alu_ready_c0", 32'(alu_ready), 1);
        tick(); idle();
        @(negedge clk); chk("alu_wr_c1", 32'(wr_en), 0);
        tick();
        @(negedge clk); chk("alu_wr_c2", 32'(wr_en), 1);
        chk("alu_regW_c2", 32'(regW), 5);
        tick();
        @(negedge clk); chk("alu_wr_c3", 32'(wr_en), 0);

        // LSU beats a non-empty FIFO
        tick();
        alu_valid = 1'b1; alu_rd = 3; alu_data = 32'h11;
        expect_wr(7, 32'h22);
        expect_wr(3, 32'h11);
        @(negedge clk);
        tick(); idle();
        mem_valid = 1'b1; mem_rd = 7; mem_data = 32'h22;
        @(negedge clk); chk("prio_mem_ready", 32'(mem_ready), 1);
        tick(); idle();
        @(negedge clk); chk("prio_first", 32'(regW), 7);
        tick();
        @(negedge clk); chk("prio_second", 32'(regW), 3);
        chk("prio_second_en", 32'(wr_en), 1);
        tick();
        @(negedge clk); chk("prio_idle", 32'(wr_en), 0);

        // full FIFO preempts the LSU for one cycle
        for (int i = 0; i < 4; i++) expect_wr(RW'(10 + i), 32'hB0 + i);
        expect_wr(20, 32'hA0);
        expect_wr(14, 32'hB4);
        for (int i = 1; i < 4; i++) expect_wr(RW'(20 + i), 32'hA0 + i);
        for (int i = 0; i < 4; i++) begin
            tick();
            alu_valid = 1'b1; alu_rd = RW'(20 + i); alu_data = 32'hA0 + i;
            mem_valid = 1'b1; mem_rd = RW'(10 + i); mem_data = 32'hB0 + i;
            @(negedge clk);
        end
        tick();
        alu_valid = 1'b0;
        mem_rd = 14; mem_data = 32'hB4;
        @(negedge clk);
        chk("full_count", 32'(dut.u_fifo.count_o), 4);
        chk("full_alu_ready", 32'(alu_ready), 0);
        chk("full_mem_ready", 32'(mem_ready), 0);
        tick();
        @(negedge clk);
        chk("full_head_wr", 32'(regW), 20);
        chk("resume_mem_ready", 32'(mem_ready), 1);
        tick(); idle();
        @(negedge clk); chk("resume_mem_wr", 32'(regW), 14);
        repeat (4) tick();
        @(negedge clk);
        chk("drain_count", 32'(dut.u_fifo.count_o), 0);
        chk("drain_idle", 32'(wr_en), 0);

        // x0 results are accepted and dropped
        tick();
        alu_valid = 1'b1; alu_rd = 0; alu_data = 32'h55;
        mem_valid = 1'b1; mem_rd = 0; mem_data = 32'h66;
        issue_valid = 1'b1; issue_rd = 0;
        @(negedge clk);
        chk("x0_alu_ready", 32'(alu_ready), 1);
        chk("x0_mem_ready", 32'(mem_ready), 1);
        tick(); idle();
        @(negedge clk);
        chk("x0_count", 32'(dut.u_fifo.count_o), 0);
        chk("x0_busy", busy, 0);
        tick();
        @(negedge clk);
        chk("x0_wr_en", 32'(wr_en), 0);

        // scoreboard set/clear and set-wins-over-clear
        tick();
        issue_valid = 1'b1; issue_rd = 9;
        @(negedge clk);
        tick(); idle();
        mem_valid = 1'b1; mem_rd = 9; mem_data = 32'h99;
        expect_wr(9, 32'h99);
        @(negedge clk); chk("sb_set", 32'(busy[9]), 1);
        tick(); idle();
        @(negedge clk); chk("sb_commit_cycle", 32'(busy[9]), 1);
        tick();
        issue_valid = 1'b1; issue_rd = 9;
        @(negedge clk); chk("sb_cleared", 32'(busy[9]), 0);
        tick(); idle();
        mem_valid = 1'b1; mem_rd = 9; mem_data = 32'h9A;
        expect_wr(9, 32'h9A);
        @(negedge clk); chk("sb_reset2", 32'(busy[9]), 1);
        tick(); idle();
        issue_valid = 1'b1; issue_rd = 9;
        @(negedge clk); chk("sb_same_wr", 32'(wr_en), 1);
        tick(); idle();
        mem_valid = 1'b1; mem_rd = 9; mem_data = 32'h9B;
        expect_wr(9, 32'h9B);
        @(negedge clk); chk("sb_set_wins", 32'(busy[9]), 1);
        tick(); idle();
        @(negedge clk);
        tick();
        @(negedge clk); chk("sb_final_clear", 32'(busy[9]), 0);

        // asynchronous reset with three buffered ALU results
        for (int i = 0; i < 3; i++) begin
            tick();
            alu_valid = 1'b1; alu_rd = RW'(i + 1); alu_data = 32'hC0 + i;
            mem_valid = 1'b1; mem_rd = 0; mem_data = 32'h0;
            issue_valid = (i == 0); issue_rd = 15;
            @(negedge clk);
        end
        tick(); idle();
        @(negedge clk);
        chk("mid_count", 32'(dut.u_fifo.count_o), 3);
        chk("mid_busy", 32'(busy[15]), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_wr_en", 32'(wr_en), 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_count", 32'(dut.u_fifo.count_o), 0);
        chk("mid_rst_alu_ready", 32'(alu_ready), 0);
        chk("mid_rst_mem_ready", 32'(mem_ready), 0);
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rel_alu_ready", 32'(alu_ready), 1);
        chk("mid_rel_mem_ready", 32'(mem_ready), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            chk("mid_no_stale", 32'(wr_en), 0);
        end
        chk("mid_count_after", 32'(dut.u_fifo.count_o), 0);

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
